aes_dec_engine: RTL
===================

# aes_dec_engine

Iterative AES-128 inverse-cipher engine, the decrypting counterpart of the HWPE encryption engine. It consumes ciphertext as a 32-bit HWPE stream and emits plaintext on a second HWPE stream. It is controlled from the HWPE controller through `ctrl_i`/`flags_o`. Processing is one round per cycle: the key is expanded forward once per job to obtain round key 10, and round keys are then regenerated backwards on the fly, so no round-key storage array is needed.

## Interface
- `NB_BLK_W`, default 16: width of the job block count.
- `clk_i` input 1: single clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `test_mode_i` input 1: unused; present for HWPE port uniformity.
- `a_i` sink `hwpe_stream_intf_stream` (DATA_WIDTH 32): ciphertext beats.
- `b_o` source `hwpe_stream_intf_stream` (DATA_WIDTH 32): plaintext beats.
- `ctrl_i` input `ctrl_engine_t`, with these fields:
  - `start`: 1-cycle pulse.
  - `clear`: 1-cycle pulse.
  - `key[127:0]`.
  - `nb_blk[NB_BLK_W-1:0]`.
- `flags_o` output `flags_engine_t`, with these fields:
  - `busy`.
  - `done`: 1-cycle pulse.
  - `blk_cnt[NB_BLK_W-1:0]`: completed blocks.

## Operation
- **FSM states:** IDLE, KEYEXP, LOAD, ROUND, STORE.
- **Reset/clear values:**
  - State is IDLE.
  - `busy`, `done`, `blk_cnt`, `a_i.ready`, `b_o.valid` are all 0.
  - `b_o.data` is 0.
- **Byte order:**
  - Word k carries state bytes 4k..4k+3, with byte 4k in `data[31:24]` (FIPS-197 text order).
  - Word 0 is first on both streams.
- **IDLE:** `start` latches `key` and `nb_blk`, clears `blk_cnt` and goes to KEYEXP. If `nb_blk`==0, the FSM stays in IDLE and pulses `done` the next cycle.
- **KEYEXP:** 10 cycles of the forward key-schedule step, round counter 1..10. Result k10 goes into `rk10_q` and the working key `rk_q`; then LOAD.
- **LOAD:**
  - `a_i.ready`=1.
  - Each handshake shifts one word in.
  - On the 4th handshake, `state_q` ← block ⊕ k10, round counter ← 9, then ROUND.
  - `a_i.strb` is ignored.
- **ROUND (10 cycles):**
  - Step backwards: `rk_q` ← k(r).
  - Datapath: `state_q` ← InvMixColumns(InvSubBytes(InvShiftRows(state_q)) ⊕ k(r)) for r=9..1.
  - At r=0, InvMixColumns is omitted.
  - Then `rk_q` ← `rk10_q` and go to STORE.
- **STORE:**
  - `b_o.valid`=1, `strb`=4'hF.
  - Words 0..3 are presented in order; each advances only on `b_o.ready`.
  - After word 3 is accepted, `blk_cnt`+1.
  - If `blk_cnt`+1 == `nb_blk`: pulse `done`, go to IDLE. Otherwise go to LOAD.
- **Arithmetic:**
  - GF(2^8) multiply by 9/11/13/14 uses xtime chains with polynomial 0x11B.
  - Backward key step: w[i-4] = w[i] ⊕ f(w[i-1]), where f = SubWord∘RotWord ⊕ Rcon only on the first word of the round key.
- **Boundaries:**
  - `start` while `busy` is ignored.
  - `clear` in any state returns to IDLE in the next cycle with reset values; partially loaded words and a pending output beat are discarded.
  - `clear` and `start` in the same cycle: `clear` wins.
  - `blk_cnt` saturates; it never wraps, because the job ends at `nb_blk`.
  - `b_o.data`/`valid` stay stable while `ready`=0.

## Timing
- `busy`=1 from the cycle after `start` until the cycle `done` pulses.
- Start-to-LOAD is 10 cycles (KEYEXP).
- Ready-only throughput: the last input beat is accepted at cycle T, ROUND occupies T+1..T+10, and the first output beat is valid at T+11.
- Block period is 4 + 10 + 4 = 18 cycles; LOAD and STORE do not overlap.
- `done` is asserted in the cycle after the last output handshake.

## Configuration
- **`AES_DEC_KEY_CACHE_EN` defined:**
  - A `key_vld_q` bit and the cached 128-bit key are kept.
  - `start` with `key` equal to the cached key and `key_vld_q`=1 skips KEYEXP and goes directly to LOAD the next cycle.
  - `clear` and reset clear `key_vld_q`.
- **Not defined:** KEYEXP always runs, 10 cycles per job.

## Structure
- `aes_dec_package` holds:
  - the `SBOX` and `INV_SBOX` 256×8 constant arrays;
  - the `RCON` array;
  - the state enum;
  - the `ctrl_engine_t` and `flags_engine_t` typedefs.
- Sub-module `aes_key_step`: combinational; input is a 128-bit key plus `rcon` plus a direction bit; output is the next or previous round key. It is instantiated once and shared by KEYEXP (forward) and ROUND (backward).

## Test plan
- **FIPS-197 C.1:**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, `nb_blk`=1, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: output 00112233445566778899aabbccddeeff, `done` at the cycle after the 4th output beat, `blk_cnt`=1.
- **FIPS-197 B:**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32.
  - Required: output 3243f6a8885a308d313198a2e0370734; internal `rk10_q` = d014f9a8c9ee2589e13f0cc8b6630ca6.
- **Multi-block with backpressure:**
  - Stimulus: `nb_blk`=3 using the C.1 block three times; `b_o.ready` toggles 1010…; random `a_i.valid` gaps.
  - Required: three identical correct blocks, data stable while stalled, `blk_cnt` 1→2→3.
- **Ideal timing:**
  - Stimulus: ready/valid held at 1.
  - Required: start-to-first-output is 10+4+10+1 = 25 cycles; 18 cycles between blocks.
- **Clear mid-ROUND:**
  - Stimulus: `clear` mid-ROUND, then restart.
  - Required: the cycle after clear shows IDLE with all outputs 0; the next job decrypts correctly.
- **Key cache (`AES_DEC_KEY_CACHE_EN` only):**
  - Stimulus: a second `start` with the same key.
  - Required: LOAD entered 1 cycle after `start`.
- **`nb_blk`=0:**
  - Required: `done` pulses 1 cycle after `start`; `a_i.ready` is never asserted.

Source files
------------

// File: rtl/aes_dec_engine_pkg.sv
// Shared types, constant tables and GF(2^8) helpers for the AES-128
// inverse-cipher engine (aes_dec_engine).
package aes_dec_package;

  localparam int unsigned ENG_NB_BLK_W = 16;

  typedef enum logic [2:0] {IDLE, KEYEXP, LOAD, ROUND, STORE} aes_state_e;

  typedef struct packed {
    logic                    start;
    logic                    clear;
    logic [127:0]            key;
    logic [ENG_NB_BLK_W-1:0] nb_blk;
  } ctrl_engine_t;

  typedef struct packed {
    logic                    busy;
    logic                    done;
    logic [ENG_NB_BLK_W-1:0] blk_cnt;
  } flags_engine_t;

  // AES state as 16 bytes, byte 0 in the most significant position.
  typedef logic [0:15][7:0] blk_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Rcon for key-schedule rounds 1..10 (index 0 is round 1).
  localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Row r rotates right by r: out(col c,row r) = in(col (c-r) mod 4, row r).
  function automatic blk_t inv_shift_rows(input blk_t s);
    return {s[0],  s[13], s[10], s[7],
            s[4],  s[1],  s[14], s[11],
            s[8],  s[5],  s[2],  s[15],
            s[12], s[9],  s[6],  s[3]};
  endfunction

  function automatic blk_t inv_sub_bytes(input blk_t s);
    blk_t o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[i] = INV_SBOX[s[i]];
    return o;
  endfunction

  function automatic blk_t inv_mix_columns(input blk_t s);
    blk_t o;
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        a[r]   = s[4*c+r];
        x2     = xtime(a[r]);
        x4     = xtime(x2);
        x8     = xtime(x4);
        m9[r]  = x8 ^ a[r];
        m11[r] = x8 ^ x2 ^ a[r];
        m13[r] = x8 ^ x4 ^ a[r];
        m14[r] = x8 ^ x4 ^ x2;
      end
      o[4*c+0] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
      o[4*c+1] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
      o[4*c+2] = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
      o[4*c+3] = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
    end
    return o;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal HWPE stream interface: valid/ready handshake with data and byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (k(i-1) -> k(i)) or backward
// (k(i) -> k(i-1)); rcon is the constant belonging to round i in both cases.
module aes_key_step
  import aes_dec_package::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  input  logic         inv,
  output logic [127:0] key_nxt
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p3;

  assign {w0, w1, w2, w3} = key;

  // Forward: n0 = w0 ^ f(w3), n(j) = w(j) ^ n(j-1). Backward undoes it,
  // recovering the old last word first because f depends on it.
  always_comb begin
    key_nxt = '0;
    p3      = w3 ^ w2;
    if (!inv) begin
      key_nxt[127:96] = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
      key_nxt[95:64]  = w1 ^ key_nxt[127:96];
      key_nxt[63:32]  = w2 ^ key_nxt[95:64];
      key_nxt[31:0]   = w3 ^ key_nxt[63:32];
    end else begin
      key_nxt[127:96] = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon, 24'h0};
      key_nxt[95:64]  = w1 ^ w0;
      key_nxt[63:32]  = w2 ^ w1;
      key_nxt[31:0]   = p3;
    end
  end

endmodule

// File: rtl/aes_dec_engine.sv
// Iterative AES-128 inverse cipher, one round per cycle, 32-bit HWPE streams.
// Optional feature macro: AES_DEC_KEY_CACHE_EN (skip KEYEXP on a repeated key).
module aes_dec_engine
  import aes_dec_package::*;
#(
  parameter int unsigned NB_BLK_W = ENG_NB_BLK_W
)(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   test_mode_i,
  hwpe_stream_intf_stream.sink   a_i,
  hwpe_stream_intf_stream.source b_o,
  input  ctrl_engine_t           ctrl_i,
  output flags_engine_t          flags_o
);

  aes_state_e          st_q;
  logic [3:0]          rnd_q;
  logic [1:0]          wcnt_q;
  logic [127:0]        rk_q;
  logic [127:0]        rk10_q;
  logic [127:0]        state_q;
  logic [95:0]         inbuf_q;
  logic [NB_BLK_W-1:0] nb_blk_q;
  logic [NB_BLK_W-1:0] blk_cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [31:0]         out_data_q;
`ifdef AES_DEC_KEY_CACHE_EN
  logic                key_vld_q;
  logic [127:0]        key_cache_q;
`endif

  logic                step_inv;
  logic [3:0]          rcon_idx;
  logic [7:0]          step_rcon;
  logic [127:0]        step_key;
  logic [127:0]        round_add;
  logic [127:0]        round_nxt;
  logic [NB_BLK_W-1:0] blk_inc;
  logic                a_hs;
  logic                b_hs;
  logic                unused_ok;

  assign unused_ok = ^{test_mode_i, a_i.strb};

  assign a_hs    = in_ready_q & a_i.valid;
  assign b_hs    = out_valid_q & b_o.ready;
  assign blk_inc = blk_cnt_q + 1'b1;

  assign a_i.ready = in_ready_q;
  assign b_o.valid = out_valid_q;
  assign b_o.data  = out_data_q;
  assign b_o.strb  = {4{out_valid_q}};

  // Flags are straight copies of registered state.
  always_comb begin
    flags_o         = '0;
    flags_o.busy    = busy_q;
    flags_o.done    = done_q;
    flags_o.blk_cnt = ENG_NB_BLK_W'(blk_cnt_q);
  end

  // Shared key step: forward in KEYEXP (round rnd_q), backward in ROUND
  // where rk_q holds k(rnd_q+1) and the constant of round rnd_q+1 applies.
  always_comb begin
    step_inv  = (st_q == ROUND);
    rcon_idx  = step_inv ? rnd_q : rnd_q - 4'd1;
    step_rcon = (rcon_idx < 4'd10) ? RCON[rcon_idx] : 8'h00;
  end

  aes_key_step u_key_step (
    .key     (rk_q),
    .rcon    (step_rcon),
    .inv     (step_inv),
    .key_nxt (step_key)
  );

  // Round datapath; the final round (rnd_q == 0) skips InvMixColumns.
  always_comb begin
    round_add = inv_sub_bytes(inv_shift_rows(state_q)) ^ step_key;
    round_nxt = (rnd_q == 4'd0) ? round_add : inv_mix_columns(round_add);
  end

  // Control FSM and datapath registers; clear behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || ctrl_i.clear) begin
      st_q        <= IDLE;
      rnd_q       <= '0;
      wcnt_q      <= '0;
      rk_q        <= '0;
      rk10_q      <= '0;
      state_q     <= '0;
      inbuf_q     <= '0;
      nb_blk_q    <= '0;
      blk_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      key_vld_q   <= 1'b0;
      key_cache_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        IDLE: begin
          if (ctrl_i.start) begin
            nb_blk_q  <= ctrl_i.nb_blk[NB_BLK_W-1:0];
            blk_cnt_q <= '0;
            rk_q      <= ctrl_i.key;
            if (ctrl_i.nb_blk[NB_BLK_W-1:0] == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
              if (key_vld_q && (ctrl_i.key == key_cache_q)) begin
                rk_q       <= rk10_q;
                wcnt_q     <= '0;
                in_ready_q <= 1'b1;
                st_q       <= LOAD;
              end else begin
                key_cache_q <= ctrl_i.key;
                key_vld_q   <= 1'b0;
                rnd_q       <= 4'd1;
                st_q        <= KEYEXP;
              end
`else
              rnd_q <= 4'd1;
              st_q  <= KEYEXP;
`endif
            end
          end
        end
        KEYEXP: begin
          rk_q <= step_key;
          if (rnd_q == 4'd10) begin
            rk10_q     <= step_key;
            wcnt_q     <= '0;
            in_ready_q <= 1'b1;
            st_q       <= LOAD;
`ifdef AES_DEC_KEY_CACHE_EN
            key_vld_q  <= 1'b1;
`endif
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        LOAD: begin
          if (a_hs) begin
            inbuf_q <= {inbuf_q[63:0], a_i.data};
            wcnt_q  <= wcnt_q + 2'd1;
            if (wcnt_q == 2'd3) begin
              state_q    <= {inbuf_q, a_i.data} ^ rk10_q;
              rnd_q      <= 4'd9;
              in_ready_q <= 1'b0;
              st_q       <= ROUND;
            end
          end
        end
        ROUND: begin
          state_q <= round_nxt;
          if (rnd_q == 4'd0) begin
            rk_q        <= rk10_q;
            wcnt_q      <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= round_nxt[127:96];
            st_q        <= STORE;
          end else begin
            rk_q  <= step_key;
            rnd_q <= rnd_q - 4'd1;
          end
        end
        STORE: begin
          if (b_hs) begin
            wcnt_q <= wcnt_q + 2'd1;
            unique case (wcnt_q)
              2'd0: out_data_q <= state_q[95:64];
              2'd1: out_data_q <= state_q[63:32];
              2'd2: out_data_q <= state_q[31:0];
              default: begin
                out_valid_q <= 1'b0;
                if (!(&blk_cnt_q)) blk_cnt_q <= blk_inc;
                if (blk_inc == nb_blk_q) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  st_q   <= IDLE;
                end else begin
                  in_ready_q <= 1'b1;
                  st_q       <= LOAD;
                end
              end
            endcase
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule
